// File: rtl/row_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : row_decoder_seq
// Purpose  : Sequenced precharge -> wordline-pulse row driver for the CAM/MAC
//            array (single MAC read, CAM key search, multi-row MAC sweep).
// Revision : 1.0
// ============================================================================
module row_decoder_seq #(
    parameter int ROWS      = 4,
    parameter int ADDR_W    = 2,
    parameter int PRE_CYC   = 1,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic              read_bar,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] addr_end,
    input  logic [ROWS-1:0]   key,
    output logic              busy,
    output logic              pre_en,
    output logic [ROWS-1:0]   WL,
    output logic [ROWS-1:0]   WLB,
    output logic              row_valid,
    output logic [ADDR_W-1:0] row_idx,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_DRIVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]        c_mode_read  = 2'b00;
    localparam logic [1:0]        c_mode_cam   = 2'b01;
    localparam logic [1:0]        c_mode_sweep = 2'b10;
    localparam logic [ADDR_W:0]   c_rows       = (ADDR_W+1)'(ROWS);
    localparam logic [CNT_W-1:0]  c_pre_last   = CNT_W'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  c_pulse_last = CNT_W'(PULSE_CYC - 1);
    localparam logic [ROWS-1:0]   c_one        = ROWS'(1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          mode_q;
    logic                rbar_q;
    logic [ADDR_W-1:0]   row_q;
    logic [ADDR_W-1:0]   end_q;
    logic [ROWS-1:0]     key_q;
    logic                err_flag_q;
    logic                busy_q;
    logic                pre_en_q;
    logic [ROWS-1:0]     wl_q;
    logic [ROWS-1:0]     wlb_q;
    logic                row_valid_q;
    logic [ADDR_W-1:0]   row_idx_q;
    logic                done_q;
    logic                err_q;

    logic [1:0]          mode_in_d;
    logic [ADDR_W-1:0]   row_next_d;
    logic                cam_d;
    logic                row_oor_d;

    function automatic logic is_oor(input logic [ADDR_W-1:0] r);
        return {1'b0, r} >= c_rows;
    endfunction

    // Out-of-range MAC rows drive nothing on either rail; CAM ignores the row.
    function automatic logic [ROWS-1:0] wl_pat(input logic cam, input logic rbar,
                                               input logic [ADDR_W-1:0] r,
                                               input logic [ROWS-1:0] k);
        logic [ROWS-1:0] oh;
        oh = c_one << r;
        if (cam)            return k;
        else if (is_oor(r)) return '0;
        else if (rbar)      return ~oh;
        else                return oh;
    endfunction

    function automatic logic [ROWS-1:0] wlb_pat(input logic cam, input logic rbar,
                                                input logic [ADDR_W-1:0] r,
                                                input logic [ROWS-1:0] k);
        return (cam || !is_oor(r)) ? ~wl_pat(cam, rbar, r, k) : '0;
    endfunction

    always_comb begin
        mode_in_d  = (mode == 2'b11) ? c_mode_read : mode;
        cam_d      = (mode_q == c_mode_cam);
        row_oor_d  = is_oor(row_q);
        row_next_d = ({1'b0, row_q} == c_rows - 1'b1) ? '0 : row_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= c_mode_read;
            rbar_q      <= 1'b0;
            row_q       <= '0;
            end_q       <= '0;
            key_q       <= '0;
            err_flag_q  <= 1'b0;
            busy_q      <= 1'b0;
            pre_en_q    <= 1'b0;
            wl_q        <= '0;
            wlb_q       <= '0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        mode_q     <= mode_in_d;
                        rbar_q     <= read_bar;
                        row_q      <= addr;
                        end_q      <= addr_end;
                        key_q      <= key;
                        err_flag_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (PRE_CYC > 0) begin
                            state_q  <= S_PRE;
                            cnt_q    <= c_pre_last;
                            pre_en_q <= 1'b1;
                        end else begin
                            state_q <= S_DRIVE;
                            cnt_q   <= c_pulse_last;
                            wl_q    <= wl_pat(mode_in_d == c_mode_cam, read_bar, addr, key);
                            wlb_q   <= wlb_pat(mode_in_d == c_mode_cam, read_bar, addr, key);
                        end
                    end
                end
                S_PRE: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        pre_en_q <= 1'b0;
                        wl_q     <= '0;
                        wlb_q    <= '0;
                    end else if (cnt_q == '0) begin
                        state_q  <= S_DRIVE;
                        cnt_q    <= c_pulse_last;
                        pre_en_q <= 1'b0;
                        wl_q     <= wl_pat(cam_d, rbar_q, row_q, key_q);
                        wlb_q    <= wlb_pat(cam_d, rbar_q, row_q, key_q);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        pre_en_q <= 1'b0;
                        wl_q     <= '0;
                        wlb_q    <= '0;
                    end else if (cnt_q == '0) begin
                        wl_q  <= '0;
                        wlb_q <= '0;
                        if (!cam_d) begin
                            if (row_oor_d) begin
                                err_flag_q <= 1'b1;
                            end else begin
                                row_valid_q <= 1'b1;
                                row_idx_q   <= row_q;
                            end
                        end
                        if (mode_q != c_mode_sweep || row_q == end_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= err_flag_q | (!cam_d && row_oor_d);
                        end else begin
                            row_q <= row_next_d;
                            if (PRE_CYC > 0) begin
                                state_q  <= S_PRE;
                                cnt_q    <= c_pre_last;
                                pre_en_q <= 1'b1;
                            end else begin
                                // Sweep rows are MAC-only, so the next pattern never uses the key.
                                cnt_q <= c_pulse_last;
                                wl_q  <= wl_pat(1'b0, rbar_q, row_next_d, key_q);
                                wlb_q <= wlb_pat(1'b0, rbar_q, row_next_d, key_q);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign pre_en    = pre_en_q;
    assign WL        = wl_q;
    assign WLB       = wlb_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire
